// File: rtl/imm_extend_unit.sv
// Registered, handshaked RISC-V immediate generator with a 2-entry skid buffer.
// Optional CSR uimm (Z) format enabled by defining IMMEXT_CSR_EN.
module imm_extend_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_nx;
    logic              accept, drain;
    logic              load_main, load_skid, move_skid;
    logic signed [31:0] raw32;
    logic [5:0]        sh6;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_ill;
    logic [XLEN-1:0]   skid_imm;
    logic              skid_ill;
    logic [TAG_W-1:0]  skid_tag;
    logic              unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // Every format is first formed as a signed 32-bit value so a single
    // sign-extending cast covers both XLEN settings.
    always_comb begin
        raw32   = '0;
        dec_ill = 1'b0;
        sh6     = {(XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
        unique case (immsrc)
            3'b000: raw32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: raw32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: raw32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: raw32 = {instr[31:12], 12'd0};
            3'b101: raw32 = {26'd0, sh6};
`ifdef IMMEXT_CSR_EN
            3'b110: raw32 = {27'd0, instr[19:15]};
`else
            3'b110: dec_ill = 1'b1;
`endif
            default: dec_ill = 1'b1;
        endcase
        dec_imm = XLEN'(raw32);
    end

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx  = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (accept && drain) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_nx  = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            immext      <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            skid_imm    <= '0;
            skid_ill    <= 1'b0;
            skid_tag    <= '0;
        end else begin
            if (load_main) begin
                immext      <= dec_imm;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end else if (move_skid) begin
                immext      <= skid_imm;
                out_illegal <= skid_ill;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_ill <= dec_ill;
                skid_tag <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_extend_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        r32_ready, r32_valid, r32_ill;
    logic [31:0] r32_imm;
    logic [3:0]  r32_tag;
    logic        r64_ready, r64_valid, r64_ill;
    logic [63:0] r64_imm;
    logic [3:0]  r64_tag;

    int checks;
    int failures;

    imm_extend_unit #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32_ready),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(r32_valid),
        .out_ready(out_ready), .immext(r32_imm), .out_illegal(r32_ill), .out_tag(r32_tag)
    );

    imm_extend_unit #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64_ready),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(r64_valid),
        .out_ready(out_ready), .immext(r64_imm), .out_illegal(r64_ill), .out_tag(r64_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        ill;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];

    function automatic longint fld(logic [31:0] x, int hi, int lo);
        longint unsigned ux;
        ux = {32'd0, x};
        return longint'((ux >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1));
    endfunction

    function automatic longint sext(longint v, int w);
        if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
        return v;
    endfunction

    // Reference immediates computed as numeric values from the field layout.
    function automatic exp_t model(logic [31:0] ins, logic [2:0] src, logic [3:0] tag);
        exp_t   e;
        longint v;
        v     = 0;
        e.ill = 1'b0;
        e.tag = tag;
        case (src)
            3'd0: v = sext(fld(ins, 31, 20), 12);
            3'd1: v = sext(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12);
            3'd2: v = sext(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048
                           + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2, 13);
            3'd3: v = sext(fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096
                           + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2, 21);
            3'd4: v = sext(fld(ins, 31, 12) * 4096, 32);
            3'd5: v = 0;
`ifdef IMMEXT_CSR_EN
            3'd6: v = fld(ins, 19, 15);
`else
            3'd6: e.ill = 1'b1;
`endif
            default: e.ill = 1'b1;
        endcase
        e.i64 = 64'(v);
        e.i32 = 32'(v);
        if (src == 3'd5) begin
            e.i32 = 32'(fld(ins, 24, 20));
            e.i64 = 64'(fld(ins, 25, 20));
        end
        return e;
    endfunction

    // Advance one clock; the model follows the handshake rules from its own occupancy.
    task automatic cycle();
        bit   acc, drn;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        e   = model(instr, immsrc, in_tag);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        instr = 32'hFFF00093; immsrc = 3'd0; in_tag = 4'd7;
        cycle();
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({r32_valid, r32_ready, r32_imm, r32_ill, r32_tag} !== {1'b0, 1'b1, 32'd0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset32 got v=%b r=%b imm=%h ill=%b tag=%0d want v=0 r=1 imm=0 ill=0 tag=0",
                     r32_valid, r32_ready, r32_imm, r32_ill, r32_tag);
        end
        checks++;
        if ({r64_valid, r64_ready, r64_imm, r64_ill, r64_tag} !== {1'b0, 1'b1, 64'd0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset64 got v=%b r=%b imm=%h ill=%b tag=%0d want v=0 r=1 imm=0 ill=0 tag=0",
                     r64_valid, r64_ready, r64_imm, r64_ill, r64_tag);
        end
    endtask

    logic [31:0] vi  [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFFDFF06F, 32'h123452B7, 32'h800002B7, 32'h03F0D093};
    logic [2:0]  vs  [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5};
    logic [31:0] e32 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h80000000, 32'h0000001F};
    logic [63:0] e64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                             64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000003F};

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; instr = vi[i]; immsrc = vs[i]; in_tag = 4'(i + 1);
            cycle();
            checks++;
            if (r32_valid !== 1'b1 || r32_imm !== e32[i] || r32_ill !== 1'b0 || r32_tag !== 4'(i + 1)) begin
                failures++;
                $display("FAIL b2b32[%0d] got v=%b imm=%h ill=%b tag=%0d want v=1 imm=%h ill=0 tag=%0d",
                         i, r32_valid, r32_imm, r32_ill, r32_tag, e32[i], i + 1);
            end
            checks++;
            if (r64_valid !== 1'b1 || r64_imm !== e64[i] || r64_ill !== 1'b0 || r64_tag !== 4'(i + 1)) begin
                failures++;
                $display("FAIL b2b64[%0d] got v=%b imm=%h ill=%b tag=%0d want v=1 imm=%h ill=0 tag=%0d",
                         i, r64_valid, r64_imm, r64_ill, r64_tag, e64[i], i + 1);
            end
        end
        in_valid = 1'b0;
        cycle();
        checks++;
        if (r32_valid !== 1'b0 || r64_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got v32=%b v64=%b want 0 0", r32_valid, r64_valid);
        end
    endtask

    task automatic test_illegal_csr();
        logic [31:0] z32;
        logic        zill;
        out_ready = 1'b1; in_valid = 1'b1;
        instr = $urandom(); immsrc = 3'd7; in_tag = 4'd5;
        cycle();
        checks++;
        if (r32_imm !== 32'd0 || r32_ill !== 1'b1 || r64_imm !== 64'd0 || r64_ill !== 1'b1 || r32_valid !== 1'b1) begin
            failures++;
            $display("FAIL illegal111 got v=%b imm32=%h ill32=%b imm64=%h ill64=%b want v=1 imm=0 ill=1",
                     r32_valid, r32_imm, r32_ill, r64_imm, r64_ill);
        end
        instr = ($urandom() & 32'hFFF07FFF) | 32'h000F8000; immsrc = 3'd6; in_tag = 4'd6;
`ifdef IMMEXT_CSR_EN
        z32 = 32'h1F; zill = 1'b0;
`else
        z32 = 32'h0;  zill = 1'b1;
`endif
        cycle();
        checks++;
        if (r32_imm !== z32 || r32_ill !== zill || r64_imm !== {32'd0, z32} || r64_ill !== zill || r32_tag !== 4'd6) begin
            failures++;
            $display("FAIL zfmt110 got imm32=%h ill32=%b imm64=%h ill64=%b tag=%0d want imm=%h ill=%b tag=6",
                     r32_imm, r32_ill, r64_imm, r64_ill, r32_tag, z32, zill);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held32;
        logic [63:0] held64;
        logic [3:0]  want_tag [6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
        logic        want_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'd2;
        held32 = '0; held64 = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                in_tag = 4'(i + 1);
                instr  = $urandom();
            end
            if (i == 4) out_ready = 1'b1;
            cycle();
            if (i == 1) begin
                held32 = r32_imm;
                held64 = r64_imm;
            end
            checks++;
            if (r32_valid !== 1'b1 || r32_tag !== want_tag[i] || r32_ready !== want_rdy[i]
                || r64_tag !== want_tag[i] || r64_ready !== want_rdy[i]) begin
                failures++;
                $display("FAIL bp_step[%0d] got v=%b tag32=%0d rdy32=%b tag64=%0d rdy64=%b want v=1 tag=%0d rdy=%b",
                         i, r32_valid, r32_tag, r32_ready, r64_tag, r64_ready, want_tag[i], want_rdy[i]);
            end
            checks++;
            if (q.size() == 0 || r32_imm !== q[0].i32 || r64_imm !== q[0].i64) begin
                failures++;
                $display("FAIL bp_data[%0d] got imm32=%h imm64=%h want imm32=%h imm64=%h",
                         i, r32_imm, r64_imm, (q.size() > 0) ? q[0].i32 : 32'hx, (q.size() > 0) ? q[0].i64 : 64'hx);
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (r32_imm !== held32 || r64_imm !== held64) begin
                    failures++;
                    $display("FAIL bp_stable[%0d] got imm32=%h imm64=%h want imm32=%h imm64=%h",
                             i, r32_imm, r64_imm, held32, held64);
                end
            end
            if (i == 4) in_valid = 1'b1;
            if (i == 5) in_valid = 1'b0;
        end
        cycle();
        checks++;
        if (r32_valid !== 1'b0 || r64_valid !== 1'b0 || r32_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_end got v32=%b v64=%b rdy=%b want 0 0 1", r32_valid, r64_valid, r32_ready);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'd0;
        in_tag = 4'd8; instr = $urandom(); cycle();
        in_tag = 4'd9; instr = $urandom(); cycle();
        checks++;
        if (r32_ready !== 1'b0 || r64_ready !== 1'b0 || r32_valid !== 1'b1) begin
            failures++;
            $display("FAIL rf_full got rdy32=%b rdy64=%b v=%b want 0 0 1", r32_ready, r64_ready, r32_valid);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (r32_valid !== 1'b0 || r32_ready !== 1'b1 || r64_valid !== 1'b0 || r64_ready !== 1'b1) begin
            failures++;
            $display("FAIL rf_after got v32=%b rdy32=%b v64=%b rdy64=%b want 0 1 0 1",
                     r32_valid, r32_ready, r64_valid, r64_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (r32_valid !== 1'b0 || r64_valid !== 1'b0) begin
                failures++;
                $display("FAIL rf_stale[%0d] got v32=%b v64=%b want 0 0", i, r32_valid, r64_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            instr     = $urandom();
            immsrc    = 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom());
            cycle();
            reset = 1'b0;
            checks++;
            if (r32_valid !== (q.size() > 0) || r64_valid !== (q.size() > 0)
                || r32_ready !== (q.size() < 2) || r64_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rnd_hs[%0d] got v32=%b v64=%b rdy32=%b rdy64=%b want v=%b rdy=%b",
                         i, r32_valid, r64_valid, r32_ready, r64_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if (r32_imm !== q[0].i32 || r32_ill !== q[0].ill || r32_tag !== q[0].tag
                    || r64_imm !== q[0].i64 || r64_ill !== q[0].ill || r64_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL rnd_data[%0d] got imm32=%h imm64=%h ill=%b/%b tag=%0d/%0d want imm32=%h imm64=%h ill=%b tag=%0d",
                             i, r32_imm, r64_imm, r32_ill, r64_ill, r32_tag, r64_tag,
                             q[0].i32, q[0].i64, q[0].ill, q[0].tag);
                end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; in_valid = 1'b0; instr = '0; immsrc = '0; in_tag = '0; out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_illegal_csr();
        test_backpressure();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Registered, handshaked immediate generator for the multi-cycle RISC-V core; next generation of the combinational immediate extender.
- Accepts an instruction word plus format select and produces the XLEN-wide immediate one cycle later.
- Adds a U-type and a shift-amount format, a deterministic illegal-format flag, tag pass-through, and a 2-entry skid buffer so the decode stage can stall independently.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 4, width of the opaque tag carried alongside each request.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- instr  input  32  instruction word; bits [6:0] are ignored.
- immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SH (shamt), 110 Z (optional), 111 illegal.
- in_tag  input  TAG_W  opaque tag, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- immext  output  XLEN  extended immediate.
- out_illegal  output  1  format select was illegal or disabled.
- out_tag  output  TAG_W  tag of the current result.

Behaviour:
- Synchronous reset: out_valid=0, immext=0, out_illegal=0, out_tag=0, in_ready=1. Both buffer entries are invalidated. Reset overrides any simultaneous handshake. A reset in any state, including FULL, discards all pending results.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
- Decode is combinational on the input side; the result is registered. Latency is 1 cycle: a request accepted at edge N is presented with out_valid=1 after edge N.
- Sign bit s = instr[31], replicated to XLEN. Formats:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - U: sext({instr[31:12], 12'b0}); for XLEN=64, bits [63:32] equal instr[31].
  - SH: zero-extended instr[24:20] when XLEN=32; zero-extended instr[25:20] when XLEN=64.
  - Illegal (111, or 110 when the optional feature is off): immext=0, out_illegal=1. Never X.
- Buffer: a main entry drives the outputs; a skid entry holds one overflow result.
  - EMPTY: main invalid. Accept -> ONE.
  - ONE:
    - accept && !drain -> FULL (new result into skid).
    - accept && drain -> ONE (new result into main).
    - drain && !accept -> EMPTY.
  - FULL:
    - drain -> ONE (skid moves to main).
    - No accept is possible in FULL.
- in_ready is registered: in_ready = !skid_valid. There is no combinational path from out_ready to in_ready.
- While out_valid && !out_ready, immext, out_illegal and out_tag are held stable.
- Strict FIFO order. No result is dropped or duplicated.
- in_valid while in_ready=0 is ignored; the producer must hold the request.

Optional Feature:
- Macro: IMMEXT_CSR_EN.
- Defined: immsrc 110 = Z format, immext = zero-extended instr[19:15] (CSR uimm), out_illegal=0.
- Undefined: 110 is treated as illegal (immext=0, out_illegal=1).
- All other formats are unaffected either way.

Test Plan:
- XLEN=32, out_ready=1. Accept instr=0xFFF00093, immsrc=000, tag=3 -> next cycle out_valid=1, immext=0xFFFFFFFF, out_tag=3, out_illegal=0.
- Back-to-back formats:
  - 0xFE112E23 with immsrc 001 -> 0xFFFFFFFC.
  - 0xFFDFF06F with immsrc 011 -> 0xFFFFFFFC.
  - 0x123452B7 with immsrc 100 -> 0x12345000.
  - Expect one result per cycle, in order.
- XLEN=64:
  - 0x800002B7 with immsrc 100 -> 0xFFFFFFFF80000000.
  - 0x03F0D093 with immsrc 101 -> 0x000000000000003F.
- Backpressure: hold out_ready=0, offer tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; in_ready=0 after the second accept; tag 3 stalls.
  - Outputs stay stable.
  - Raise out_ready: results emerge with tags 1, 2, 3; in_ready returns to 1 one cycle after the first drain.
- immsrc=111 -> immext=0, out_illegal=1.
- immsrc=110 with instr[19:15]=0x1F:
  - Macro defined -> immext=0x1F, out_illegal=0.
  - Macro undefined -> immext=0, out_illegal=1.
- Reset mid-FULL: assert reset for 1 cycle with both entries valid -> out_valid=0, in_ready=1 after the edge, no stale results emitted afterwards.
